// File: rtl/tqvp_jnms_pdm_tx.sv
// PDM transmitter peripheral: buffers 16-bit signed PCM samples in a small FIFO
// and streams them out as a first-order sigma-delta bitstream with its own clock.
`timescale 1ns/1ps
module tqvp_jnms_pdm_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef logic [15:0] sample_t;

  logic          en_q, en_d, ie_q, ie_d;
  logic [2:0]    thr_q, thr_d;
  logic [7:0]    clkdiv_q, clkdiv_d, osr_q, osr_d;
  sample_t       mem_q [FIFO_DEPTH];
  sample_t       mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]    level_q, level_d;
  logic          underrun_q, underrun_d, overflow_q, overflow_d;
  logic [7:0]    p_q, p_d, b_q, b_d;
  sample_t       acc_q, acc_d, cur_q, cur_d;
  logic          pdm_clk_q, pdm_clk_d, pdm_dat_q, pdm_dat_d, irq_q, irq_d;

  logic          wr_any, wr_ctrl, wr_clkdiv, wr_data, wr_status, wr_osr, flush;
  logic [7:0]    d_eff, half;
  logic          bit_event, pop_req, do_pop, do_push, fifo_empty, fifo_full;
  sample_t       head, sample;
  logic [16:0]   sum;
  logic          unused_bits;

  // Bus write decode; every register field lives in the low byte, so any width updates it
  always_comb begin
    wr_any    = (data_write_n != 2'b11);
    wr_ctrl   = wr_any && (address == 6'h00);
    wr_clkdiv = wr_any && (address == 6'h04);
    wr_data   = wr_any && (address == 6'h08);
    wr_status = wr_any && (address == 6'h0C);
    wr_osr    = wr_any && (address == 6'h10);
    flush     = wr_ctrl && data_in[1];
  end

  // Software-visible configuration registers (FLUSH is a pulse, never stored)
  always_comb begin
    en_d     = en_q;
    thr_d    = thr_q;
    ie_d     = ie_q;
    clkdiv_d = clkdiv_q;
    osr_d    = osr_q;
    if (wr_ctrl) begin
      en_d  = data_in[0];
      thr_d = data_in[4:2];
      ie_d  = data_in[5];
    end
    if (wr_clkdiv) clkdiv_d = data_in[7:0];
    if (wr_osr)    osr_d    = data_in[7:0];
  end

  // PDM timing: effective divider, half point and the bit event at the falling edge
  always_comb begin
    d_eff     = (clkdiv_q < 8'd2) ? 8'd2 : clkdiv_q;
    half      = {1'b0, d_eff[7:1]};
    bit_event = en_q && (p_q == half);
    pop_req   = bit_event && (b_q == 8'd0);
  end

  // FIFO bookkeeping: a pop on empty underruns, a push on full overflows unless a pop frees a slot
  always_comb begin
    fifo_empty = (level_q == 4'd0);
    fifo_full  = (level_q == 4'(FIFO_DEPTH));
    head       = mem_q[rd_ptr_q];
    do_pop     = pop_req && !fifo_empty;
    do_push    = wr_data && !flush && (!fifo_full || do_pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q + 4'(do_push) - 4'(do_pop);
    underrun_d = underrun_q;
    overflow_d = overflow_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_in[15:0];
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = 4'd0;
    end
    if (wr_status && data_in[2]) underrun_d = 1'b0;
    if (wr_status && data_in[3]) overflow_d = 1'b0;
    if (pop_req && fifo_empty) underrun_d = 1'b1;
    if (wr_data && !flush && fifo_full && !do_pop) overflow_d = 1'b1;
  end

  // Phase/bit counters and the first-order sigma-delta modulator
  always_comb begin
    p_d       = 8'd0;
    b_d       = b_q;
    acc_d     = acc_q;
    cur_d     = cur_q;
    pdm_clk_d = 1'b0;
    pdm_dat_d = pdm_dat_q;
    sample    = cur_q;
    sum       = '0;
    if (!en_q) begin
      b_d       = 8'd0;
      acc_d     = '0;
      cur_d     = '0;
      pdm_dat_d = 1'b0;
    end else begin
      p_d       = (p_q >= d_eff - 8'd1) ? 8'd0 : p_q + 8'd1;
      pdm_clk_d = (p_q < half);
      if (bit_event) begin
        b_d       = (b_q >= osr_q - 8'd1) ? 8'd0 : b_q + 8'd1;
        if (pop_req) sample = fifo_empty ? 16'h0000 : head;
        cur_d     = sample;
        sum       = {1'b0, acc_q} + {1'b0, sample ^ 16'h8000};
        pdm_dat_d = sum[16];
        acc_d     = sum[15:0];
      end
    end
  end

  // Interrupt request: FIFO running low or an underrun has happened
  always_comb begin
    irq_d = ie_q && en_q && (({1'b0, thr_q} >= level_q) || underrun_q);
  end

  // Register readback, purely a function of the address
  always_comb begin
    data_out = 32'h0;
    case (address)
      6'h00:   data_out = {26'b0, ie_q, thr_q, 1'b0, en_q};
      6'h04:   data_out = {24'b0, clkdiv_q};
      6'h08:   data_out = {16'b0, cur_q};
      6'h0C:   data_out = {24'b0, level_q, overflow_q, underrun_q, fifo_full, fifo_empty};
      6'h10:   data_out = {24'b0, osr_q};
      default: data_out = 32'h0;
    endcase
  end

  // State registers, all cleared asynchronously so the PDM outputs drop at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      thr_q      <= '0;
      clkdiv_q   <= '0;
      osr_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      p_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cur_q      <= '0;
      pdm_clk_q  <= 1'b0;
      pdm_dat_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      ie_q       <= ie_d;
      thr_q      <= thr_d;
      clkdiv_q   <= clkdiv_d;
      osr_q      <= osr_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      p_q        <= p_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cur_q      <= cur_d;
      pdm_clk_q  <= pdm_clk_d;
      pdm_dat_q  <= pdm_dat_d;
      irq_q      <= irq_d;
    end
  end

  assign uo_out         = {5'b0, pdm_dat_q, pdm_clk_q, 1'b0};
  assign data_ready     = 1'b1;
  assign user_interrupt = irq_q;
  assign unused_bits    = &{1'b0, ui_in, data_read_n, data_in[31:16]};

endmodule

// File: tb/tb_tqvp_jnms_pdm_tx.sv
// Directed self-checking bench for the PDM transmitter peripheral.
`timescale 1ns/1ps
module tb_tqvp_jnms_pdm_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ui_in = 8'h00;
  logic [7:0]  uo_out;
  logic [5:0]  address = 6'h00;
  logic [31:0] data_in = 32'h0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int checks = 0;
  int passes = 0;

  localparam logic [5:0] A_CTRL = 6'h00, A_CLKDIV = 6'h04, A_DATA = 6'h08,
                         A_STATUS = 6'h0C, A_OSR = 6'h10;

  tqvp_jnms_pdm_tx #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out), .address(address),
    .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt)
  );

  // 100 MHz bench clock
  always #5 clk = ~clk;

  // Safety net against a hung wait
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
    @(negedge clk);
    address = a; data_in = d; data_write_n = w;
    @(negedge clk);
    data_write_n = 2'b11; data_in = 32'h0; address = 6'h00;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] v);
    address = a; data_read_n = 2'b10;
    #1;
    v = data_out;
    data_read_n = 2'b11;
  endtask

  // Wait for a pdm_clk edge (sampled at negedges), bounded
  task automatic wait_edge(input bit rising, output bit ok);
    logic prev;
    prev = uo_out[1];
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rising ? (!prev && uo_out[1]) : (prev && !uo_out[1])) begin
        ok = 1'b1;
        break;
      end
      prev = uo_out[1];
    end
  endtask

  // Record pdm_dat after each pdm_clk falling edge; also count data changes away
  // from a falling edge and high/low runs that are not 2 cycles long (D=4)
  task automatic collect_bits(input int n, output logic [31:0] bits, output int dat_bad,
                              output int run_bad, output bit ok);
    logic pc, pd, c, d;
    int k, run, cyc;
    bit seen;
    pc = uo_out[1]; pd = uo_out[2];
    k = 0; run = 0; cyc = 0; seen = 0; bits = '0; dat_bad = 0; run_bad = 0;
    while (k < n && cyc < n * 16 + 100) begin
      @(negedge clk);
      cyc++;
      c = uo_out[1]; d = uo_out[2];
      if (d !== pd && !(pc && !c)) dat_bad++;
      if (c !== pc) begin
        if (seen && run != 2) run_bad++;
        seen = 1; run = 1;
      end else run++;
      if (pc && !c) begin bits[k] = d; k++; end
      pc = c; pd = d;
    end
    ok = (k == n);
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    checks++; if (uo_out !== 8'h00) $display("[TB] FAIL reset_uo_out: got %h expected 00", uo_out); else passes++;
    checks++; if (data_ready !== 1'b1) $display("[TB] FAIL reset_data_ready: got %b expected 1", data_ready); else passes++;
    checks++; if (user_interrupt !== 1'b0) $display("[TB] FAIL reset_irq: got %b expected 0", user_interrupt); else passes++;
    bus_read(A_STATUS, v);
    checks++; if (v !== 32'h1) $display("[TB] FAIL reset_status: got %h expected 00000001", v); else passes++;
    bus_read(A_CTRL, v);
    checks++; if (v !== 32'h0) $display("[TB] FAIL reset_ctrl: got %h expected 0", v); else passes++;
    bus_read(A_CLKDIV, v);
    checks++; if (v !== 32'h0) $display("[TB] FAIL reset_clkdiv: got %h expected 0", v); else passes++;
    bus_read(A_OSR, v);
    checks++; if (v !== 32'h0) $display("[TB] FAIL reset_osr: got %h expected 0", v); else passes++;
    bus_read(A_DATA, v);
    checks++; if (v !== 32'h0) $display("[TB] FAIL reset_data: got %h expected 0", v); else passes++;
  endtask

  task automatic test_registers();
    logic [31:0] v;
    do_reset();
    bus_write(A_CTRL, 32'h3C, 2'b00);
    bus_read(A_CTRL, v);
    checks++; if (v !== 32'h3C) $display("[TB] FAIL ctrl_rw: got %h expected 0000003c", v); else passes++;
    bus_write(A_CTRL, 32'h02, 2'b10);
    bus_read(A_CTRL, v);
    checks++; if (v !== 32'h0) $display("[TB] FAIL ctrl_flush_reads0: got %h expected 0", v); else passes++;
    bus_write(A_CLKDIV, 32'h12345678, 2'b10);
    bus_read(A_CLKDIV, v);
    checks++; if (v !== 32'h78) $display("[TB] FAIL clkdiv_rw: got %h expected 00000078", v); else passes++;
    bus_write(A_OSR, 32'hA5, 2'b00);
    bus_read(A_OSR, v);
    checks++; if (v !== 32'hA5) $display("[TB] FAIL osr_rw: got %h expected 000000a5", v); else passes++;
    bus_write(6'h14, 32'hFFFFFFFF, 2'b10);
    bus_read(6'h14, v);
    checks++; if (v !== 32'h0) $display("[TB] FAIL unmapped: got %h expected 0", v); else passes++;
    bus_write(A_DATA, 32'hDEADBEEF, 2'b10);
    bus_write(A_DATA, 32'h1234, 2'b01);
    bus_read(A_STATUS, v);
    checks++; if (v !== 32'h20) $display("[TB] FAIL push_level2: got %h expected 00000020", v); else passes++;
    bus_read(A_DATA, v);
    checks++; if (v !== 32'h0) $display("[TB] FAIL data_idle: got %h expected 0", v); else passes++;
    bus_write(A_CTRL, 32'h02, 2'b00);
    bus_read(A_STATUS, v);
    checks++; if (v !== 32'h1) $display("[TB] FAIL flush_empty: got %h expected 00000001", v); else passes++;
  endtask

  task automatic test_midscale();
    logic [31:0] bits;
    int db, rb;
    bit ok;
    do_reset();
    bus_write(A_CLKDIV, 32'd4, 2'b00);
    bus_write(A_OSR, 32'd8, 2'b00);
    bus_write(A_DATA, 32'h0000, 2'b00);
    bus_write(A_CTRL, 32'h01, 2'b00);
    collect_bits(8, bits, db, rb, ok);
    checks++; if (!ok) $display("[TB] FAIL mid_timeout: got fewer than 8 bits"); else passes++;
    checks++; if (bits[7:0] !== 8'hAA) $display("[TB] FAIL mid_bits: got %b expected 10101010 (first bit at lsb)", bits[7:0]); else passes++;
    checks++; if (db != 0) $display("[TB] FAIL mid_dat_edge: got %0d changes off falling edge expected 0", db); else passes++;
    checks++; if (rb != 0) $display("[TB] FAIL mid_clk_period: got %0d bad runs expected 0", rb); else passes++;
  endtask

  task automatic test_extremes();
    logic [31:0] bits;
    int db, rb;
    bit ok;
    do_reset();
    bus_write(A_CLKDIV, 32'd4, 2'b00);
    bus_write(A_OSR, 32'd8, 2'b00);
    bus_write(A_DATA, 32'h7FFF, 2'b01);
    bus_write(A_DATA, 32'h8000, 2'b01);
    bus_write(A_CTRL, 32'h01, 2'b00);
    collect_bits(16, bits, db, rb, ok);
    checks++; if (!ok) $display("[TB] FAIL ext_timeout: got fewer than 16 bits"); else passes++;
    checks++; if (bits[15:0] !== 16'h00FE) $display("[TB] FAIL ext_bits: got %h expected 00fe (first bit at lsb)", bits[15:0]); else passes++;
    checks++; if (db != 0) $display("[TB] FAIL ext_dat_edge: got %0d expected 0", db); else passes++;
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    logic [31:0] exp;
    bit ok;
    do_reset();
    for (int i = 1; i <= 5; i++) bus_write(A_DATA, 32'(i), 2'b01);
    bus_read(A_STATUS, v);
    checks++; if (v !== 32'h4A) $display("[TB] FAIL ovf_status: got %h expected 0000004a", v); else passes++;
    bus_write(A_CLKDIV, 32'd4, 2'b00);
    bus_write(A_OSR, 32'd1, 2'b00);
    bus_write(A_CTRL, 32'h01, 2'b00);
    for (int k = 1; k <= 5; k++) begin
      wait_edge(1'b0, ok);
      checks++; if (!ok) $display("[TB] FAIL ovf_edge_timeout: event %0d not seen", k); else passes++;
      bus_read(A_DATA, v);
      exp = (k <= 4) ? 32'(k) : 32'h0;
      checks++; if (v !== exp) $display("[TB] FAIL ovf_pop_order: event %0d got %h expected %h", k, v, exp); else passes++;
    end
    bus_write(A_STATUS, 32'h08, 2'b00);
    bus_read(A_STATUS, v);
    checks++; if (v[3:2] !== 2'b01) $display("[TB] FAIL ovf_clear: got flags %b expected 01", v[3:2]); else passes++;
  endtask

  task automatic test_underrun_irq();
    logic [31:0] bits;
    logic [31:0] v;
    int db, rb, irq_bad;
    bit ok, found;
    do_reset();
    bus_write(A_CLKDIV, 32'd4, 2'b00);
    bus_write(A_OSR, 32'd8, 2'b00);
    bus_write(A_CTRL, 32'h25, 2'b00);
    collect_bits(9, bits, db, rb, ok);
    checks++; if (!ok) $display("[TB] FAIL und_timeout: got fewer than 9 bits"); else passes++;
    checks++; if (bits[8:0] !== 9'h0AA) $display("[TB] FAIL und_bits: got %b expected 010101010", bits[8:0]); else passes++;
    bus_read(A_STATUS, v);
    checks++; if (v !== 32'h05) $display("[TB] FAIL und_status: got %h expected 00000005", v); else passes++;
    checks++; if (user_interrupt !== 1'b1) $display("[TB] FAIL und_irq: got %b expected 1", user_interrupt); else passes++;
    bus_write(A_STATUS, 32'h04, 2'b01);
    bus_write(A_DATA, 32'h1111, 2'b01);
    bus_write(A_DATA, 32'h2222, 2'b01);
    @(negedge clk);
    bus_read(A_STATUS, v);
    checks++; if (v !== 32'h20) $display("[TB] FAIL und_cleared: got %h expected 00000020", v); else passes++;
    checks++; if (user_interrupt !== 1'b0) $display("[TB] FAIL irq_level2: got %b expected 0", user_interrupt); else passes++;
    irq_bad = 0; found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bus_read(A_STATUS, v);
      if (v[7:4] == 4'd1) begin found = 1; break; end
      if (user_interrupt) irq_bad++;
    end
    checks++; if (!found) $display("[TB] FAIL irq_pop_timeout: level never reached 1"); else passes++;
    checks++; if (irq_bad != 0) $display("[TB] FAIL irq_early: got %0d cycles high expected 0", irq_bad); else passes++;
    checks++; if (v[2] !== 1'b0) $display("[TB] FAIL und_after_pop: got %b expected 0", v[2]); else passes++;
    @(negedge clk);
    checks++; if (user_interrupt !== 1'b1) $display("[TB] FAIL irq_level1: got %b expected 1", user_interrupt); else passes++;
  endtask

  task automatic test_coincidence();
    logic [31:0] v;
    bit ok;
    do_reset();
    bus_write(A_CLKDIV, 32'd4, 2'b00);
    bus_write(A_OSR, 32'd1, 2'b00);
    bus_write(A_CTRL, 32'h01, 2'b00);
    wait_edge(1'b1, ok);
    checks++; if (!ok) $display("[TB] FAIL coin_sync_timeout: no rising edge"); else passes++;
    bus_write(A_DATA, 32'h1234, 2'b01);
    bus_read(A_STATUS, v);
    checks++; if (v !== 32'h14) $display("[TB] FAIL coin_status: got %h expected 00000014", v); else passes++;
    bus_read(A_DATA, v);
    checks++; if (v !== 32'h0) $display("[TB] FAIL coin_sample0: got %h expected 0", v); else passes++;
    wait_edge(1'b0, ok);
    bus_read(A_DATA, v);
    checks++; if (v !== 32'h1234) $display("[TB] FAIL coin_next_pop: got %h expected 00001234", v); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    bit ok;
    do_reset();
    for (int i = 1; i <= 4; i++) bus_write(A_DATA, 32'(i * 16'h11), 2'b01);
    bus_write(A_CLKDIV, 32'd4, 2'b00);
    bus_write(A_OSR, 32'd1, 2'b00);
    bus_write(A_CTRL, 32'h01, 2'b00);
    wait_edge(1'b1, ok);
    checks++; if (!ok) $display("[TB] FAIL b2b_sync_timeout: no rising edge"); else passes++;
    bus_write(A_DATA, 32'h55, 2'b00);
    bus_read(A_STATUS, v);
    checks++; if (v !== 32'h42) $display("[TB] FAIL b2b_full_status: got %h expected 00000042", v); else passes++;
    bus_read(A_DATA, v);
    checks++; if (v !== 32'h11) $display("[TB] FAIL b2b_first: got %h expected 00000011", v); else passes++;
    for (int k = 2; k <= 5; k++) begin
      wait_edge(1'b0, ok);
      bus_read(A_DATA, v);
      checks++; if (v !== 32'(k * 16'h11)) $display("[TB] FAIL b2b_order: pop %0d got %h expected %h", k, v, 32'(k * 16'h11)); else passes++;
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] bits;
    logic [31:0] v;
    int db, rb;
    bit ok;
    do_reset();
    bus_write(A_CLKDIV, 32'd4, 2'b00);
    bus_write(A_OSR, 32'd8, 2'b00);
    for (int i = 0; i < 4; i++) bus_write(A_DATA, 32'h7FFF, 2'b01);
    bus_write(A_CTRL, 32'h01, 2'b00);
    collect_bits(2, bits, db, rb, ok);
    bus_read(A_STATUS, v);
    checks++; if (v !== 32'h30) $display("[TB] FAIL mid_rst_level3: got %h expected 00000030", v); else passes++;
    checks++; if (uo_out !== 8'h04) $display("[TB] FAIL mid_rst_pre_uo: got %h expected 04", uo_out); else passes++;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (uo_out !== 8'h00) $display("[TB] FAIL mid_rst_async_uo: got %h expected 00", uo_out); else passes++;
    checks++; if (user_interrupt !== 1'b0) $display("[TB] FAIL mid_rst_irq: got %b expected 0", user_interrupt); else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    bus_read(A_STATUS, v);
    checks++; if (v !== 32'h1) $display("[TB] FAIL mid_rst_status: got %h expected 00000001", v); else passes++;
    checks++; if (uo_out !== 8'h00) $display("[TB] FAIL mid_rst_idle_uo: got %h expected 00", uo_out); else passes++;
  endtask

  initial begin
    $display("[TB] starting tqvp_jnms_pdm_tx bench");
    test_reset();
    test_registers();
    test_midscale();
    test_extremes();
    test_overflow();
    test_underrun_irq();
    test_coincidence();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tqvp_jnms_pdm_tx.md
TQVP_JNMS_PDM_TX -- requirements
Module: tqvp_jnms_pdm_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: number of 16-bit PCM samples buffered (power of two, 2..8).
REQ-002 SHALL have ports:
- clk  in  1  project clock (64 MHz nominal)
- rst  in  1  asynchronous, active-high reset
- ui_in  in  8  unused
- uo_out  out  8  [1]=pdm_clk, [2]=pdm_dat, all other bits 0
- address  in  6  register offset
- data_in  in  32  write data
- data_write_n  in  2  11 none / 00 8b / 01 16b / 10 32b
- data_read_n  in  2  11 none / 00 8b / 01 16b / 10 32b
- data_out  out  32  read data
- data_ready  out  1  constant 1
- user_interrupt  out  1  interrupt request

Function
REQ-003 SHALL decode these registers; bytes are written per data_write_n width, and unlisted addresses read 0 and ignore writes:
- 0x0 CTRL: [0] EN, [1] FLUSH (self-clearing, reads 0), [4:2] THR, [5] IE.
- 0x4 CLKDIV: [7:0], PDM clock period in clk cycles; values 0 and 1 are treated as 2.
- 0x8 DATA: a write of any width pushes data_in[15:0] as a signed sample; a read returns the current sample, zero-extended.
- 0xC STATUS: [0] empty, [1] full, [2] underrun (sticky), [3] overflow (sticky), [7:4] level. Writing 1 to [2] or [3] clears that bit.
- 0x10 OSR: [7:0], PDM bits per sample; 0 is treated as 256.
REQ-004 SHALL, while EN=1, run phase counter P from 0 to D-1 and wrap to 0, where D is the effective CLKDIV.
REQ-005 SHALL register pdm_clk = (P < D>>1), giving a period of D clk cycles with the rising edge at P=0.
REQ-006 SHALL treat the cycle with P == D>>1 (PDM falling edge) as a bit event, so pdm_dat is stable at every rising edge.
REQ-007 SHALL, at each bit event, advance bit counter B through 0..OSR-1 and wrap to 0.
REQ-008 SHALL, at a bit event with B==0, pop the FIFO head into the current-sample register.
REQ-009 SHALL, if the FIFO is empty at that pop, load 0x0000 and set underrun.
REQ-010 SHALL, at each bit event, use a first-order modulator with 16-bit accumulator A:
- compute {c, A'} = A + (sample XOR 0x8000), a 17-bit sum;
- register pdm_dat <= c and A <= A'.
- The sample used is the one loaded at this same event when B==0.
REQ-011 SHALL, with EN=0, hold pdm_clk=0, pdm_dat=0, P=0, B=0, A=0 and the current sample at 0; FIFO contents are retained so software can prefill.
REQ-012 SHALL make the first bit event after EN goes 0->1 occur D>>1 cycles after the first P=0 cycle.
REQ-013 SHALL, on a DATA write when the FIFO is full, drop the sample, set overflow and leave the FIFO unchanged.
REQ-014 SHALL perform push and pop in the same cycle when the FIFO is non-empty and not full: level unchanged, order preserved.
REQ-015 SHALL, when a push coincides with a pop while the FIFO is empty, take the underrun path (REQ-009) and store the pushed sample, giving level=1.
REQ-016 SHALL, when a push coincides with a pop while the FIFO is full, perform both and not set overflow.
REQ-017 SHALL, on a FLUSH write, empty the FIFO in one cycle; a DATA write in the same cycle is discarded.
REQ-018 SHALL drive user_interrupt = IE & EN & ((level <= THR) | underrun), registered.
REQ-019 SHALL return read data combinationally from address, independent of data_read_n; reads have no side effects.

Reset
REQ-020 SHALL, while rst is high, asynchronously clear:
- all registers (CTRL=0, CLKDIV=0, OSR=0);
- FIFO pointers and level;
- the underrun and overflow flags;
- P, B, A, the current sample, pdm_clk, pdm_dat and user_interrupt.
REQ-021 SHALL, after reset, read STATUS=0x01 and drive uo_out=0x00.
REQ-022 SHALL, on reset assertion mid-stream, force pdm_clk and pdm_dat to 0 with no clock edge required, and discard buffered samples.

Verification
REQ-023 Reset: assert rst mid-stream (EN=1, level=3) -> uo_out=0x00 immediately; STATUS reads 0x01; user_interrupt=0.
REQ-024 Mid-scale: CLKDIV=4, OSR=8, push 0x0000, EN=1 -> pdm_clk period 4, 2 high/2 low; pdm_dat sequence 0,1,0,1,…, changing only at falling edges.
REQ-025 Extremes: push 0x7FFF -> first 8 bits 0,1,1,1,1,1,1,1; then push 0x8000 -> the next 8 bits are all 0.
REQ-026 Overflow: EN=0, push 5 samples 0x0001..0x0005 -> level=4, full=1, overflow=1; EN=1 pops 1..4 in order, 0x0005 is never output.
REQ-027 Underrun/IRQ: IE=1, THR=1, EN=1 with an empty FIFO -> underrun=1, user_interrupt=1, pattern as for 0x0000; write STATUS=0x04 plus push 2 samples -> underrun=0; user_interrupt=0 until level<=1.
REQ-028 Coincidence: push on the same cycle as a B==0 bit event with the FIFO empty -> underrun=1 and level=1.
